// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, NOP encoding, PC step and default fetch vectors.
package cpu_pkg;
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_TRAP_PC  = 32'h0000_0004;
endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures fetched pc/instr, hold freezes it, flush inserts a NOP bubble.
// Latency: one edge. Flush beats hold; a flushed entry keeps the previous id_pc.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            hold_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic            id_valid_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      id_pc_o    <= '0;
      id_instr_o <= NOP_INSTR;
      id_valid_o <= 1'b0;
    end else if (flush_i) begin
      id_instr_o <= NOP_INSTR;
      id_valid_o <= 1'b0;
    end else if (!hold_i) begin
      id_pc_o    <= pc_i;
      id_instr_o <= instr_i;
      id_valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: PC register, next-PC select, delivered-instruction counter, IF/ID register.
// Latency: instr at pc_o reaches IF/ID next edge; stall holds everything, redirect overrides stall.
// Optional IF_MISALIGN_TRAP_EN: misaligned redirect targets go to TRAP_PC and set sticky misalign_o.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [XLEN-1:0] TRAP_PC  = DEFAULT_TRAP_PC
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic [XLEN-1:0] pc_o,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] id_pc_o,
  output logic [XLEN-1:0] id_instr_o,
  output logic            id_valid_o,
  output logic [XLEN-1:0] fetch_cnt_o,
  output logic            misalign_o
);

  logic [XLEN-1:0] redirect_target;
  logic            advance;

  assign advance = !redirect_i && !stall_i;

`ifdef IF_MISALIGN_TRAP_EN
  logic misalign_hit;

  assign misalign_hit    = redirect_i && (redirect_pc_i[1:0] != 2'b00);
  assign redirect_target = misalign_hit ? TRAP_PC : redirect_pc_i;

  always_ff @(posedge clk_i) begin
    if (rst_i)             misalign_o <= 1'b0;
    else if (misalign_hit) misalign_o <= 1'b1;
  end
`else
  logic unused_trap_pc;

  assign unused_trap_pc  = ^TRAP_PC;
  assign redirect_target = redirect_pc_i;
  assign misalign_o      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i)           pc_o <= RESET_PC;
    else if (redirect_i) pc_o <= redirect_target;
    else if (!stall_i)   pc_o <= pc_o + PC_STEP;
  end

  // Counts only entries that land in IF/ID as valid; wraps modulo 2^32.
  always_ff @(posedge clk_i) begin
    if (rst_i)        fetch_cnt_o <= '0;
    else if (advance) fetch_cnt_o <= fetch_cnt_o + 1'b1;
  end

  if_id_reg u_if_id_reg (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .hold_i     (stall_i),
    .flush_i    (redirect_i),
    .pc_i       (pc_o),
    .instr_i    (instr_i),
    .id_pc_o    (id_pc_o),
    .id_instr_o (id_instr_o),
    .id_valid_o (id_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: directed fetch/stall/redirect/wrap/reset scenarios then random traffic.
module tb_if_stage;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TRP_PC = 32'h0000_0004;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_o;
  logic [31:0] instr_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_valid_o;
  logic [31:0] fetch_cnt_o;
  logic        misalign_o;

  int checks = 0;
  int errors = 0;
  bit done   = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] cnt;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  exp_t m;

  if_stage #(.RESET_PC(RST_PC), .TRAP_PC(TRP_PC)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .pc_o(pc_o), .instr_i(instr_i),
    .id_pc_o(id_pc_o), .id_instr_o(id_instr_o), .id_valid_o(id_valid_o),
    .fetch_cnt_o(fetch_cnt_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'd11;
      32'h4:   return 32'd22;
      32'h8:   return 32'd33;
      default: return {a[15:0], a[31:16]} ^ 32'h5A5A_1234;
    endcase
  endfunction

  // Instruction memory answers combinationally for whatever address is fetched.
  always_comb instr_i = mem_word(pc_o);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: one architectural update per clock edge from the spec's priority rules.
  task automatic model_edge(input bit r, input bit s, input bit d, input logic [31:0] rpc);
    if (r) begin
      m.pc = RST_PC; m.id_pc = 0; m.id_instr = 0; m.id_valid = 0; m.cnt = 0; m.mis = 0;
    end else if (d) begin
`ifdef IF_MISALIGN_TRAP_EN
      if (rpc % 4 != 0) begin
        m.pc = TRP_PC; m.mis = 1;
      end else m.pc = rpc;
`else
      m.pc = rpc;
`endif
      m.id_valid = 0; m.id_instr = 0;
    end else if (!s) begin
      m.id_pc = m.pc; m.id_instr = mem_word(m.pc); m.id_valid = 1;
      m.pc = m.pc + 4; m.cnt = m.cnt + 1;
    end
  endtask

  task automatic step(input bit r, input bit s, input bit d, input logic [31:0] rpc);
    @(negedge clk_i);
    rst_i = r; stall_i = s; redirect_i = d; redirect_pc_i = rpc;
    @(posedge clk_i);
    model_edge(r, s, d, rpc);
    exp_q.push_back(m);
  endtask

  // Monitor: every edge produces a new output set; compare it mid-cycle.
  always @(negedge clk_i) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_o", pc_o, e.pc);
      chk("id_pc_o", id_pc_o, e.id_pc);
      chk("id_instr_o", id_instr_o, e.id_instr);
      chk("id_valid_o", {31'b0, id_valid_o}, {31'b0, e.id_valid});
      chk("fetch_cnt_o", fetch_cnt_o, e.cnt);
      chk("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
    end
  end

  initial begin
    m = '{default: '0};
    // Reset, free-run, stall at pc 8, release.
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Redirect wins over stall.
    step(0, 1, 1, 32'h40);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // PC wrap at the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Misaligned redirect, then advance.
    step(0, 0, 1, 32'h42);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Reset during a stall with a valid IF/ID entry, then recover.
    step(0, 1, 0, 0);
    step(1, 1, 1, 32'h80);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bit r, s, d;
      logic [31:0] rpc;
      r   = ($urandom_range(49) == 0);
      s   = ($urandom_range(3) == 0);
      d   = ($urandom_range(7) == 0);
      rpc = $urandom;
      if ($urandom_range(3) != 0) rpc[1:0] = 2'b00;
      step(r, s, d, rpc);
    end
    @(negedge clk_i);
    @(negedge clk_i);
    chk("scoreboard_drained", exp_q.size(), 0);
    done = 1'b1;
  end

  initial begin
    wait (done);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, got running, expected done");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_0004, meaning fetch target on a misaligned redirect (REQ-019 only).
REQ-003 SHALL have ports: clk_i  in  1  sole clock, rising edge; rst_i  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: stall_i  in  1  hold PC and IF/ID; redirect_i  in  1  branch/jump taken; redirect_pc_i  in  32  redirect target.
REQ-005 SHALL have ports: pc_o  out  32  fetch address to instruction memory; instr_i  in  32  instruction word returned combinationally for pc_o.
REQ-006 SHALL have ports: id_pc_o  out  32  PC of decoded instr; id_instr_o  out  32  instr to decode; id_valid_o  out  1  IF/ID holds real instr.
REQ-007 SHALL have ports: fetch_cnt_o  out  32  count of instructions delivered to IF/ID; misalign_o  out  1  misaligned redirect seen (REQ-019 only; tied 0 otherwise).

Function
REQ-008 SHALL hold pc_o in a register; instruction memory read is combinational, so instr_i for pc_o is sampled in the same cycle.
REQ-009 SHALL apply per-edge priority: rst_i > redirect_i > stall_i > normal advance.
REQ-010 Normal advance: pc_o <= pc_o+4; id_pc_o <= pc_o; id_instr_o <= instr_i; id_valid_o <= 1; fetch_cnt_o += 1.
REQ-011 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC advances to 32'h0000_0000 with no flag.
REQ-012 Stall (stall_i=1, redirect_i=0): pc_o, id_pc_o, id_instr_o, id_valid_o, fetch_cnt_o SHALL all hold.
REQ-013 Redirect (redirect_i=1): pc_o <= redirect_pc_i; id_valid_o <= 0; id_instr_o <= NOP (32'h0000_0000); id_pc_o holds; fetch_cnt_o holds; applies even if stall_i=1.
REQ-014 Latency: the instruction at address A SHALL appear on id_instr_o with id_valid_o=1 exactly one edge after pc_o=A with no stall/redirect.
REQ-015 fetch_cnt_o SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-016 Outputs SHALL be driven only from registers except pc_o (also a register); no combinational path from stall_i/redirect_i to any output.

Reset
REQ-017 On a rising edge with rst_i=1: pc_o=RESET_PC, id_pc_o=0, id_instr_o=NOP, id_valid_o=0, fetch_cnt_o=0, misalign_o=0, regardless of other inputs.
REQ-018 Reset asserted mid-operation (including during stall or redirect) SHALL discard all state; first valid IF/ID entry is RESET_PC one edge after rst_i falls.

Configuration
REQ-019 Macro IF_MISALIGN_TRAP_EN: when defined, a redirect with redirect_pc_i[1:0]!=0 SHALL load pc_o=TRAP_PC and set misalign_o=1 (sticky until reset); when undefined, redirect_pc_i is loaded unchanged and misalign_o is constant 0.

Structure
REQ-020 Shared package cpu_pkg SHALL hold XLEN=32, NOP_INSTR=32'h0000_0000, PC_STEP=4, default RESET_PC/TRAP_PC.
REQ-021 IF/ID register (id_pc/id_instr/id_valid with hold and flush controls) SHALL be a sub-module if_id_reg; PC register, next-PC mux and counter stay in if_stage.

Verification
REQ-022 Reset then 3 free-running cycles, memory word at 0/4/8 = 11/22/33 -> pc_o 0,4,8,12; id_instr_o NOP(valid 0),11,22,33; fetch_cnt_o 0,1,2,3.
REQ-023 stall_i=1 for 2 cycles at pc_o=8 -> pc_o stays 8, id_instr_o stays 22, fetch_cnt_o stays 2; release -> id_instr_o 33 next edge.
REQ-024 redirect_i=1, redirect_pc_i=32'h40, stall_i=1 same cycle -> next edge pc_o=32'h40, id_valid_o=0, id_instr_o=0; following edge id_pc_o=32'h40, valid 1.
REQ-025 pc_o forced to 32'hFFFF_FFFC via redirect, then advance -> pc_o=0, no flag, fetch_cnt_o increments.
REQ-026 With IF_MISALIGN_TRAP_EN, redirect_pc_i=32'h42 -> pc_o=TRAP_PC, misalign_o=1 until rst_i; without macro -> pc_o=32'h42, misalign_o=0.
REQ-027 rst_i=1 during stall with id_valid_o=1 -> next edge all outputs at REQ-017 values.
